// File: rtl/digit_serial_addsub.sv
// Digit-serial add/subtract for two's complement and signed-magnitude operands.
// Each ADD cycle pushes one DIGIT_WIDTH slice through a ripple adder and keeps the carry in a register.
module digit_serial_addsub #(
    parameter int ADDER_WIDTH = 32,
    parameter int DIGIT_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [ADDER_WIDTH-1:0] a_in,
    input  logic [ADDER_WIDTH-1:0] b_in,
    input  logic                   sm2c_sel,
    input  logic                   addsub_sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ADDER_WIDTH-1:0] sum_out,
    output logic                   overflow_out,
    output logic                   carry_out
);
    localparam int W          = ADDER_WIDTH;
    localparam int D          = DIGIT_WIDTH;
    localparam int NUM_DIGITS = W / D;
    localparam int CNT_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    if (ADDER_WIDTH % DIGIT_WIDTH != 0) begin : g_bad_width
        $error("ADDER_WIDTH must be a multiple of DIGIT_WIDTH");
    end

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE.
    typedef enum logic [1:0] {IDLE, ADD, FIX, DONE} state_t;

    state_t           state;
    logic [W-1:0]     op_a, op_b, result;
    logic             ext_a, ext_b, mode_sm, carry;
    logic [CNT_W-1:0] cnt;

    logic [D-1:0] dig_a, dig_b, dig_s;
    logic         dig_c, msb_cin, last_digit;
    logic [W-1:0] next_result;

    always_comb begin
        dig_a           = op_a[int'(cnt)*D +: D];
        dig_b           = op_b[int'(cnt)*D +: D];
        {dig_c, dig_s}  = {1'b0, dig_a} + {1'b0, dig_b} + {{D{1'b0}}, carry};
        msb_cin         = dig_s[D-1] ^ dig_a[D-1] ^ dig_b[D-1];
        next_result     = result;
        next_result[int'(cnt)*D +: D] = dig_s;
        last_digit      = (cnt == CNT_W'(NUM_DIGITS - 1));
    end

    // Signed-magnitude operands become W+1-bit two's complement; a zero magnitude is +0.
    logic [W-2:0] a_mag, b_mag;
    logic         a_neg, b_neg;
    logic [W:0]   a_ext, b_ext;

    always_comb begin
        a_mag = a_in[W-2:0];
        b_mag = b_in[W-2:0];
        a_neg = a_in[W-1] & (|a_mag);
        b_neg = (b_in[W-1] ^ addsub_sel) & (|b_mag);
        a_ext = a_neg ? -{2'b00, a_mag} : {2'b00, a_mag};
        b_ext = b_neg ? -{2'b00, b_mag} : {2'b00, b_mag};
    end

    // The W+1-bit SM sum has magnitude below 2^W, so its low W bits negate exactly.
    logic         bit_w;
    logic [W-1:0] mag;

    always_comb begin
        bit_w = ext_a ^ ext_b ^ carry;
        mag   = bit_w ? (~result + W'(1)) : result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            out_valid    <= 1'b0;
            sum_out      <= '0;
            overflow_out <= 1'b0;
            carry_out    <= 1'b0;
            carry        <= 1'b0;
            cnt          <= '0;
            op_a         <= '0;
            op_b         <= '0;
            result       <= '0;
            ext_a        <= 1'b0;
            ext_b        <= 1'b0;
            mode_sm      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        mode_sm  <= sm2c_sel;
                        cnt      <= '0;
                        in_ready <= 1'b0;
                        state    <= ADD;
                        if (sm2c_sel) begin
                            op_a  <= a_ext[W-1:0];
                            ext_a <= a_ext[W];
                            op_b  <= b_ext[W-1:0];
                            ext_b <= b_ext[W];
                            carry <= 1'b0;
                        end else begin
                            op_a  <= a_in;
                            ext_a <= 1'b0;
                            op_b  <= addsub_sel ? ~b_in : b_in;
                            ext_b <= 1'b0;
                            carry <= addsub_sel;
                        end
                    end
                end
                ADD: begin
                    result <= next_result;
                    carry  <= dig_c;
                    cnt    <= cnt + CNT_W'(1);
                    if (last_digit) begin
                        if (mode_sm) begin
                            state <= FIX;
                        end else begin
                            sum_out      <= next_result;
                            carry_out    <= dig_c;
                            overflow_out <= dig_c ^ msb_cin;
                            out_valid    <= 1'b1;
                            state        <= DONE;
                        end
                    end
                end
                FIX: begin
                    sum_out      <= {bit_w & (|mag), mag[W-2:0]};
                    overflow_out <= mag[W-1];
                    carry_out    <= mag[W-1];
                    out_valid    <= 1'b1;
                    state        <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub at W=8, D=4: directed corner cases, backpressure,
// mid-operation reset and randomized operations against an arithmetic reference model.
module tb_digit_serial_addsub;
    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready;
    logic [W-1:0] a_in, b_in;
    logic         sm2c_sel, addsub_sel;
    logic         out_valid, out_ready;
    logic [W-1:0] sum_out;
    logic         overflow_out, carry_out;

    int n_tests = 0;
    int n_fail  = 0;
    logic [9:0] exp_q[$];

    digit_serial_addsub #(.ADDER_WIDTH(W), .DIGIT_WIDTH(D)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a_in(a_in), .b_in(b_in),
        .sm2c_sel(sm2c_sel), .addsub_sel(addsub_sel),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum_out(sum_out), .overflow_out(overflow_out), .carry_out(carry_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: returns {carry, overflow, sum} from plain integer arithmetic.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic sm, input logic sub);
        int va, vb, r, mag;
        logic [7:0] nb, s;
        logic ov, c;
        if (!sm) begin
            va = int'($signed(a));
            vb = int'($signed(b));
            r  = sub ? va - vb : va + vb;
            s  = r[7:0];
            ov = (r > 127) || (r < -128);
            nb = ~b;
            c  = sub ? ((int'(a) + int'(nb) + 1) >= 256) : ((int'(a) + int'(b)) >= 256);
        end else begin
            va  = (a[6:0] == 7'd0) ? 0 : (a[7] ? -int'(a[6:0]) : int'(a[6:0]));
            vb  = (b[6:0] == 7'd0) ? 0 : (b[7] ? -int'(b[6:0]) : int'(b[6:0]));
            if (sub) vb = -vb;
            r   = va + vb;
            mag = (r < 0) ? -r : r;
            ov  = (mag >= 128);
            s   = {(r < 0), mag[6:0]};
            c   = ov;
        end
        return {c, ov, s};
    endfunction

    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic sm,
                          input logic sub, input logic [9:0] exp, input int hold);
        int waited, edges;
        logic [9:0] e;
        waited = 0;
        while (!in_ready && waited < 50) begin
            @(posedge clk); #1;
            waited++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            return;
        end
        a_in = a; b_in = b; sm2c_sel = sm; addsub_sel = sub;
        in_valid = 1'b1;
        out_ready = 1'b0;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid   = 1'b0;
        a_in       = W'($urandom);
        b_in       = W'($urandom);
        sm2c_sel   = 1'($urandom);
        addsub_sel = 1'($urandom);
        check("busy_in_ready", 32'(in_ready), 0);
        edges = 0;
        do begin
            @(posedge clk); #1;
            edges++;
        end while (!out_valid && edges < 20);
        check("latency", edges, sm ? (W / D + 1) : (W / D));
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 10'h3FF;
        check("sum", 32'(sum_out), 32'(e[7:0]));
        check("overflow", 32'(overflow_out), 32'(e[8]));
        check("carry", 32'(carry_out), 32'(e[9]));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(out_valid), 1);
            check("hold_in_ready", 32'(in_ready), 0);
            check("hold_out", {22'd0, carry_out, overflow_out, sum_out}, 32'(e));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("handoff_valid", 32'(out_valid), 0);
        check("handoff_in_ready", 32'(in_ready), 1);
    endtask

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       sm;
        logic       sub;
        logic [9:0] exp;
    } vec_t;

    vec_t vecs[8];

    initial begin
        vecs[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 10'h180};
        vecs[1] = '{8'h05, 8'h07, 1'b0, 1'b1, 10'h0FE};
        vecs[2] = '{8'h07, 8'h05, 1'b0, 1'b1, 10'h202};
        vecs[3] = '{8'h85, 8'h03, 1'b1, 1'b0, 10'h082};
        vecs[4] = '{8'h03, 8'h83, 1'b1, 1'b1, 10'h006};
        vecs[5] = '{8'h80, 8'h00, 1'b1, 1'b0, 10'h000};
        vecs[6] = '{8'h7F, 8'h01, 1'b1, 1'b0, 10'h300};
        vecs[7] = '{8'hFF, 8'h81, 1'b1, 1'b0, 10'h380};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        a_in = '0; b_in = '0; sm2c_sel = 1'b0; addsub_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 1);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_outputs", {22'd0, carry_out, overflow_out, sum_out}, 0);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].sm, vecs[i].sub, vecs[i].exp, 0);

        // Backpressure: result must stay put while out_ready is low.
        run_op(8'h7F, 8'h01, 1'b0, 1'b0, 10'h180, 5);

        // Reset after one ADD edge abandons the operation.
        a_in = 8'h12; b_in = 8'h34; sm2c_sel = 1'b0; addsub_sel = 1'b0;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_out_valid", 32'(out_valid), 0);
        check("midrst_in_ready", 32'(in_ready), 1);
        check("midrst_outputs", {22'd0, carry_out, overflow_out, sum_out}, 0);
        repeat (4) begin
            @(posedge clk); #1;
            check("midrst_no_result", 32'(out_valid), 0);
        end

        for (int i = 0; i < 40; i++) begin
            logic [7:0] ra, rb;
            logic rsm, rsub;
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            rsm  = 1'($urandom);
            rsub = 1'($urandom);
            run_op(ra, rb, rsm, rsub, model(ra, rb, rsm, rsub), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
